// File: rtl/host_iface_pkg.sv
// Shared definitions for the host-bound byte scheduler: FSM encoding and
// the width helper used for source indices and the burst counter.
package host_iface_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        CHECK = 2'd2
    } state_e;

    // Bits needed to hold values 0..n_values-1, never less than one.
    function automatic int width_of(input int n_values);
        return (n_values <= 2) ? 1 : $clog2(n_values);
    endfunction

endpackage

// File: rtl/out_sched_if.sv
// Byte-channel bundle between the requesting sources, the scheduler and the
// FT2232 transmit path.
interface out_sched_if #(
    parameter int N_SRCS = 2
);
    logic [N_SRCS-1:0] omux_req_i;
    logic [7:0]        omux_data_i;
    logic [N_SRCS-1:0] omux_sel_o;
    logic [N_SRCS-1:0] grant_o;
    logic [7:0]        out_o;
    logic              out_req_o;
    logic              out_ack_i;

    modport slave (
        input  omux_req_i, omux_data_i, out_ack_i,
        output omux_sel_o, grant_o, out_o, out_req_o
    );

    modport master (
        output omux_req_i, omux_data_i, out_ack_i,
        input  omux_sel_o, grant_o, out_o, out_req_o
    );
endinterface

// File: rtl/omux_rr_pick.sv
// Rotating-priority pick: first requesting source at or after (last+1),
// wrapping N_SRCS-1 back to 0.
module omux_rr_pick
    import host_iface_pkg::*;
#(
    parameter int N_SRCS = 2,
    parameter int IDX_W  = width_of(N_SRCS)
) (
    input  logic [N_SRCS-1:0] req_i,
    input  logic [IDX_W-1:0]  last_i,
    output logic              found_o,
    output logic [IDX_W-1:0]  idx_o
);

    // Walk the candidates from farthest to nearest so the nearest one wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = N_SRCS; k >= 1; k--) begin
            int c;
            c = (int'(last_i) + k) % N_SRCS;
            if (req_i[c]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/out_sched.sv
// Round-robin scheduler sharing one host-bound byte channel among N_SRCS
// requesters, with a per-grant burst limit of MAX_BURST bytes.
module out_sched
    import host_iface_pkg::*;
#(
    parameter int N_SRCS    = 2,
    parameter int MAX_BURST = 16
) (
    input  logic     clk_i,
    input  logic     nreset_i,
    out_sched_if.slave bus
);

    localparam int IDX_W   = width_of(N_SRCS);
    localparam int BURST_W = width_of(MAX_BURST + 1);

    logic [1:0]         rst_sync_q;
    logic               rst_n_sync;
    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [N_SRCS-1:0]  owner_oh;
    logic               owner_req;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               out_req;
    logic [N_SRCS-1:0]  sel;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) rst_sync_q <= '0;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_sync = rst_sync_q[1];

    omux_rr_pick #(.N_SRCS(N_SRCS), .IDX_W(IDX_W)) u_pick (
        .req_i   (bus.omux_req_i),
        .last_i  (last_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign owner_oh  = N_SRCS'(1) << owner_q;
    assign owner_req = |(bus.omux_req_i & owner_oh);

    always_ff @(posedge clk_i or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(N_SRCS - 1);
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        burst_d = burst_q;
        out_req = 1'b0;
        sel     = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    burst_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                out_req = 1'b1;
                // An ack takes the byte even if the owner drops its request now.
                if (bus.out_ack_i) begin
                    sel     = owner_oh;
                    burst_d = burst_q + BURST_W'(1);
                    state_d = CHECK;
                end else if (!owner_req) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            CHECK: begin
                if (owner_req && (burst_q < BURST_W'(MAX_BURST))) begin
                    state_d = REQ;
                end else begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gating with the raw reset drops the outputs without waiting on the synchroniser.
    assign bus.out_req_o  = out_req & nreset_i;
    assign bus.omux_sel_o = sel & {N_SRCS{nreset_i}};
    assign bus.grant_o    = (state_q != IDLE) ? (owner_oh & {N_SRCS{nreset_i}}) : '0;
    assign bus.out_o      = bus.omux_data_i;

endmodule

// File: tb/tb_out_sched.sv
// Scoreboard bench for out_sched (N_SRCS=2, MAX_BURST=4): stimulus queues the
// expected accepted bytes, a negedge monitor pops and compares each strobe.
module tb_out_sched;

    typedef struct {
        int         src;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       nreset;
    logic [7:0] cnt0, cnt1;
    int         n_cmp, n_bad, cyc;
    exp_t       exp_q[$];
    exp_t       mon_e;
    int         strobe_t[$];

    out_sched_if #(.N_SRCS(2)) bus ();

    out_sched #(.N_SRCS(2), .MAX_BURST(4)) dut (
        .clk_i    (clk),
        .nreset_i (nreset),
        .bus      (bus)
    );

    // Source model: src0 emits 0x00,0x01,..; src1 emits 0x80,0x81,..
    assign bus.omux_data_i = bus.grant_o[1] ? (8'h80 + cnt1) : cnt0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int src, input logic [7:0] data);
        exp_t e;
        e.src  = src;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        check(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (bus.omux_sel_o != '0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: sel=%b data=%h, none expected (t=%0t)",
                         bus.omux_sel_o, bus.out_o, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_sel",   bus.omux_sel_o, 32'(1) << mon_e.src);
                check("strobe_grant", bus.grant_o,    32'(1) << mon_e.src);
                check("strobe_req",   bus.out_req_o,  1);
                check("strobe_data",  bus.out_o,      mon_e.data);
            end
            strobe_t.push_back(cyc);
            if (bus.omux_sel_o[0]) cnt0++;
            else                   cnt1++;
        end
    end

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        cnt0 = 8'h00; cnt1 = 8'h00;
        nreset = 1'b0;
        bus.omux_req_i = 2'b00;
        bus.out_ack_i  = 1'b0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_grant",   bus.grant_o,    0);
        check("rst_out_req", bus.out_req_o,  0);
        check("rst_sel",     bus.omux_sel_o, 0);
        tick();
        nreset = 1'b1;
        repeat (5) tick();

        // Both requesting, ack always: 4-byte bursts alternate src0, src1, src0
        for (int i = 0; i < 4; i++) push(0, 8'(i));
        for (int i = 0; i < 4; i++) push(1, 8'(8'h80 + i));
        for (int i = 4; i < 8; i++) push(0, 8'(i));
        bus.out_ack_i  = 1'b1;
        bus.omux_req_i = 2'b11;
        @(negedge clk);
        check("lat_req_t0",   bus.out_req_o, 0);
        tick();
        @(negedge clk);
        check("lat_req_t1",   bus.out_req_o, 1);
        check("lat_grant_t1", bus.grant_o,   2'b01);
        drain("alt_drain");
        bus.omux_req_i = 2'b00;
        repeat (3) tick();

        // Only src1: two bursts of 4 with one IDLE cycle between them
        strobe_t.delete();
        for (int i = 4; i < 12; i++) push(1, 8'(8'h80 + i));
        bus.omux_req_i = 2'b10;
        drain("solo_drain");
        bus.omux_req_i = 2'b00;
        check("solo_count", strobe_t.size(), 8);
        if (strobe_t.size() == 8)
            for (int i = 1; i < 8; i++)
                check($sformatf("solo_gap%0d", i), strobe_t[i] - strobe_t[i-1], (i == 4) ? 3 : 2);
        repeat (3) tick();

        // src0 withdraws in REQ with no ack after 2 bytes; src1 is next
        push(0, 8'h08); push(0, 8'h09); push(1, 8'h8C);
        bus.omux_req_i = 2'b01;
        bus.out_ack_i  = 1'b1;
        tick(); tick(); tick();
        tick(); bus.out_ack_i = 1'b0;
        tick(); bus.omux_req_i = 2'b10;
        @(negedge clk);
        check("wd_req_held",  bus.out_req_o, 1);
        check("wd_grant0",    bus.grant_o,   2'b01);
        tick();
        @(negedge clk);
        check("wd_idle_req",  bus.out_req_o, 0);
        check("wd_idle_gnt",  bus.grant_o,   0);
        tick(); bus.out_ack_i = 1'b1;
        check("wd_grant1",    bus.grant_o,   2'b10);
        tick(); bus.omux_req_i = 2'b00; bus.out_ack_i = 1'b0;
        repeat (3) tick();
        check("wd_drain", exp_q.size(), 0);

        // Ack coincident with the owner dropping its request
        push(0, 8'h0A);
        bus.omux_req_i = 2'b01;
        bus.out_ack_i  = 1'b1;
        tick(); bus.omux_req_i = 2'b00;
        tick();
        @(negedge clk);
        check("co_check_req", bus.out_req_o, 0);
        check("co_check_gnt", bus.grant_o,   2'b01);
        tick();
        @(negedge clk);
        check("co_idle_gnt",  bus.grant_o,   0);
        // Ack held while idle must not strobe
        repeat (4) tick();
        check("co_drain", exp_q.size(), 0);
        bus.out_ack_i = 1'b0;

        // Reset mid-REQ with src1 owning
        bus.omux_req_i = 2'b10;
        tick(); tick();
        @(negedge clk);
        check("mr_pre_req", bus.out_req_o, 1);
        check("mr_pre_gnt", bus.grant_o,   2'b10);
        #2 nreset = 1'b0;
        #1;
        check("mr_req_drop", bus.out_req_o,  0);
        check("mr_gnt_drop", bus.grant_o,    0);
        check("mr_sel",      bus.omux_sel_o, 0);
        tick(); tick();
        bus.omux_req_i = 2'b11;
        tick(); nreset = 1'b1;
        for (int i = 0; i < 10 && bus.out_req_o !== 1'b1; i++) tick();
        check("mr_regrant_req", bus.out_req_o, 1);
        check("mr_regrant_gnt", bus.grant_o,   2'b01);
        push(0, 8'h0B);
        bus.out_ack_i = 1'b1;
        tick(); bus.omux_req_i = 2'b00; bus.out_ack_i = 1'b0;
        repeat (3) tick();
        check("final_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
